// File: rtl/synthesizer_soc_led_pkg.sv
// Shared constants for the LED activity controller: register addresses, CTRL bit
// positions and the default hold time.
package synthesizer_soc_led_pkg;

    localparam logic [1:0] ADDR_CPU_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL     = 2'd1;
    localparam logic [1:0] ADDR_HOLD     = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    localparam int MODE_BIT  = 0;
    localparam int BLEND_BIT = 1;
    localparam int DUTY_LSB  = 4;
    localparam int DUTY_MSB  = 7;

    localparam int HOLD_RST_DEF = 100;

    // PWM gate: a DUTY of d keeps the LED on for d+1 of every 16 clocks.
    function automatic logic pwm_on(input logic [3:0] cnt, input logic [3:0] duty);
        return (cnt <= duty);
    endfunction

endpackage

// File: rtl/synthesizer_soc_led_hold_timer.sv
// Per-LED hold timer: a strobe loads the hold time, each tick counts it down,
// and the LED is active while the count is non-zero.
module synthesizer_soc_led_hold_timer #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              load,
    input  logic              clear,
    input  logic [HOLD_W-1:0] hold_val,
    output logic              active
);

    logic [HOLD_W-1:0] timer_q;
    logic [HOLD_W-1:0] timer_d;

    // Clear beats load, and load beats the tick decrement.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (load) begin
            timer_d = hold_val;
        end else if (tick && (timer_q != '0)) begin
            timer_d = timer_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign active = (timer_q != '0);

endmodule

// File: rtl/synthesizer_soc_led_activity_ctrl.sv
// Avalon-MM LED bank controller blending CPU data with activity-strobe hold timers.
// Optional PWM dimming via the SYNTHESIZER_SOC_LED_PWM_DIM_EN macro.
module synthesizer_soc_led_activity_ctrl
    import synthesizer_soc_led_pkg::*;
#(
    parameter int NUM_LEDS = 14,
    parameter int TICK_DIV = 50000,
    parameter int HOLD_W   = 8,
    parameter int HOLD_RST = HOLD_RST_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] act_pulse,
    output logic [NUM_LEDS-1:0] out_port
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [NUM_LEDS-1:0] cpu_data_q;
    logic                mode_q;
    logic                blend_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [CNT_W-1:0]    presc_q;
    logic [NUM_LEDS-1:0] out_port_q;
    logic [NUM_LEDS-1:0] out_port_d;
    logic [NUM_LEDS-1:0] act_s;
    logic [NUM_LEDS-1:0] sel_s;
    logic                wr_en_s;
    logic                tick_s;
    logic                clear_s;
    logic                unused_wdata_s;

    assign wr_en_s        = chipselect && !write_n;
    assign tick_s         = (presc_q == CNT_MAX);
    assign clear_s        = wr_en_s && (address == ADDR_STATUS) && writedata[0];
    assign unused_wdata_s = ^writedata;

`ifdef SYNTHESIZER_SOC_LED_PWM_DIM_EN
    logic [3:0] duty_q;
    logic [3:0] pwm_cnt_q;

    // DUTY field and the free-running PWM phase counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q    <= 4'hF;
            pwm_cnt_q <= 4'h0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'h1;
            if (wr_en_s && (address == ADDR_CTRL)) begin
                duty_q <= writedata[DUTY_MSB:DUTY_LSB];
            end
        end
    end
`endif

    // Software-visible registers and the free-running tick prescaler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_data_q <= '0;
            mode_q     <= 1'b0;
            blend_q    <= 1'b0;
            hold_q     <= HOLD_W'(HOLD_RST);
            presc_q    <= '0;
        end else begin
            presc_q <= tick_s ? '0 : presc_q + CNT_W'(1);
            if (wr_en_s) begin
                case (address)
                    ADDR_CPU_DATA: cpu_data_q <= writedata[NUM_LEDS-1:0];
                    ADDR_CTRL: begin
                        mode_q  <= writedata[MODE_BIT];
                        blend_q <= writedata[BLEND_BIT];
                    end
                    ADDR_HOLD: hold_q <= writedata[HOLD_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_timer
        synthesizer_soc_led_hold_timer #(
            .HOLD_W (HOLD_W)
        ) u_timer (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick_s),
            .load     (act_pulse[i]),
            .clear    (clear_s),
            .hold_val (hold_q),
            .active   (act_s[i])
        );
    end

    // Display source selection, optionally gated by the PWM dimmer.
    always_comb begin
        if (blend_q) begin
            sel_s = cpu_data_q | act_s;
        end else if (mode_q) begin
            sel_s = act_s;
        end else begin
            sel_s = cpu_data_q;
        end
`ifdef SYNTHESIZER_SOC_LED_PWM_DIM_EN
        out_port_d = sel_s & {NUM_LEDS{pwm_on(pwm_cnt_q, duty_q)}};
`else
        out_port_d = sel_s;
`endif
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port_q <= '0;
        end else begin
            out_port_q <= out_port_d;
        end
    end

    assign out_port = out_port_q;

    // Read mux; bits outside each field read as zero.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CPU_DATA: readdata[NUM_LEDS-1:0] = cpu_data_q;
            ADDR_CTRL: begin
                readdata[MODE_BIT]  = mode_q;
                readdata[BLEND_BIT] = blend_q;
`ifdef SYNTHESIZER_SOC_LED_PWM_DIM_EN
                readdata[DUTY_MSB:DUTY_LSB] = duty_q;
`endif
            end
            ADDR_HOLD:   readdata[HOLD_W-1:0]   = hold_q;
            ADDR_STATUS: readdata[NUM_LEDS-1:0] = out_port_q;
            default:     readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_synthesizer_soc_led_activity_ctrl.sv
// Directed self-checking bench for the LED activity controller (TICK_DIV=4).
module tb_synthesizer_soc_led_activity_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [13:0] act_pulse = 14'd0;
    logic [13:0] out_port;

    int n_checks = 0;
    int n_pass = 0;
    int ph;
    int cnt;

`ifdef SYNTHESIZER_SOC_LED_PWM_DIM_EN
    localparam logic [31:0] DUTY_BITS = 32'h0000_00F0;
`else
    localparam logic [31:0] DUTY_BITS = 32'h0000_0000;
`endif

    synthesizer_soc_led_activity_ctrl #(
        .NUM_LEDS (14),
        .TICK_DIV (4),
        .HOLD_W   (8),
        .HOLD_RST (100)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .act_pulse  (act_pulse),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Expected prescaler phase: 0..3, wrapping; tick is active while it is 3.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ph <= 0;
        else          ph <= (ph == 3) ? 0 : ph + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic pulse_at(input int target, input logic [13:0] m);
        for (int i = 0; i < 8 && ph != target; i++) @(negedge clk);
        act_pulse = m;
        @(negedge clk);
        act_pulse = 14'd0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #23 reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_out", 32'(out_port), 32'h0);
        rd_chk("rst_rd0", 2'd0, 32'h0);
        rd_chk("rst_rd1", 2'd1, DUTY_BITS);
        rd_chk("rst_rd2", 2'd2, 32'd100);
        rd_chk("rst_rd3", 2'd3, 32'h0);

        // CPU mode, one-clock latency, readback
        bus_wr(2'd0, 32'h2AAA);
        check("cpu_lat", 32'(out_port), 32'h0);
        cyc(1);
        check("cpu_out", 32'(out_port), 32'h2AAA);
        rd_chk("cpu_rd3", 2'd3, 32'h2AAA);
        rd_chk("cpu_rd0", 2'd0, 32'h2AAA);
        bus_wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("cpu_trunc", 2'd0, 32'h3FFF);
        cyc(1);
        check("cpu_full", 32'(out_port), 32'h3FFF);
        bus_wr(2'd0, 32'h2AAA);
        pulse_at(0, 14'h0010);
        cyc(1);
        check("cpu_ign_act", 32'(out_port), 32'h2AAA);
        bus_wr(2'd3, 32'h1);

        // CTRL field widths, then activity mode with HOLD=3
        bus_wr(2'd1, 32'hFFFF_FFFF);
        rd_chk("ctrl_rd", 2'd1, DUTY_BITS | 32'h3);
        bus_wr(2'd1, DUTY_BITS | 32'h1);
        bus_wr(2'd2, 32'h0000_0103);
        rd_chk("hold_rd", 2'd2, 32'h3);
        cyc(1);
        check("act_idle", 32'(out_port), 32'h0);

        // Single strobe: lit for 11 clocks after load, then dark
        pulse_at(0, 14'h0001);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d", k), 32'(out_port), (k <= 11) ? 32'h1 : 32'h0);
        end

        // Retrigger coinciding with a tick reloads to 3 without decrement
        pulse_at(0, 14'h0001);
        pulse_at(3, 14'h0001);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("retrig%0d", k), 32'(out_port), (k <= 12) ? 32'h1 : 32'h0);
        end

        // STATUS clear together with a strobe on LED 5
        pulse_at(0, 14'h0001);
        cyc(1);
        check("pre_clr", 32'(out_port), 32'h1);
        @(negedge clk);
        act_pulse = 14'h0020; address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        act_pulse = 14'd0; chipselect = 1'b0; write_n = 1'b1;
        cyc(1);
        check("clr_out", 32'(out_port), 32'h0);
        cyc(4);
        check("clr_stay", 32'(out_port), 32'h0);

        // Blend mode
        bus_wr(2'd1, DUTY_BITS | 32'h2);
        bus_wr(2'd0, 32'h0100);
        pulse_at(0, 14'h0001);
        cyc(1);
        check("blend_out", 32'(out_port), 32'h0101);
        rd_chk("blend_rd3", 2'd3, 32'h0101);

        // HOLD=0: strobe never lights its LED
        bus_wr(2'd3, 32'h1);
        bus_wr(2'd2, 32'h0);
        rd_chk("hold0_rd", 2'd2, 32'h0);
        pulse_at(0, 14'h0002);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("hold0_%0d", k), 32'(out_port), 32'h0100);
        end

        // Asynchronous reset mid-hold
        bus_wr(2'd2, 32'h3);
        pulse_at(0, 14'h0001);
        cyc(1);
        check("pre_rst", 32'(out_port), 32'h0101);
        #2 reset_n = 1'b0;
        #1 check("async_rst", 32'(out_port), 32'h0);
        rd_chk("rst2_rd0", 2'd0, 32'h0);
        rd_chk("rst2_rd1", 2'd1, DUTY_BITS);
        rd_chk("rst2_rd2", 2'd2, 32'd100);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(2);
        check("rst2_out", 32'(out_port), 32'h0);

`ifdef SYNTHESIZER_SOC_LED_PWM_DIM_EN
        // PWM dimming: DUTY=3 gives 4 of 16, DUTY=15 gives 16 of 16
        bus_wr(2'd1, 32'h30);
        bus_wr(2'd0, 32'h3FFF);
        cyc(1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (out_port == 14'h3FFF) cnt++;
        end
        check("pwm_d3", 32'(cnt), 32'd4);
        bus_wr(2'd1, 32'hF0);
        cyc(1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (out_port == 14'h3FFF) cnt++;
        end
        check("pwm_d15", 32'(cnt), 32'd16);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
